// File: rtl/fractal_pkg.sv
// fractal_pkg: shared pixel-stream types for the fractal video pipeline
package fractal_pkg;
  localparam int PIXEL_WIDTH = 24;
  typedef struct packed {
    logic                   sof;
    logic                   eol;
    logic [PIXEL_WIDTH-1:0] pixel;
  } pixel_beat_t;
  typedef enum logic {WAIT_SOF, RUN} stream_state_t;
endpackage

// File: rtl/fractal_stream_fifo.sv
// fractal_stream_fifo: synchronous first-word-fall-through FIFO
module fractal_stream_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;
  // full/empty from extra pointer bit; a push into a full FIFO is legal when it pops the same cycle
  always_comb begin
    empty   = wr_q == rd_q;
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    dout    = mem[rd_q[AW-1:0]];
  end
  // pointer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage array, no reset needed since reads are masked by empty upstream
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fractal_stream_to_axis.sv
// fractal_stream_to_axis: colorizer pixel stream to AXI4-Stream video with overflow resync
module fractal_stream_to_axis
  import fractal_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_WIDTH,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  frame_start_in,
  input  logic                  line_end_in,
  input  logic                  data_enable_in,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  syncing
);
  localparam int EW = DATA_WIDTH + 2;
  stream_state_t        state_q, state_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                 push, pop, full, empty, space, drop, ovf_evt;
  logic [EW-1:0]        dout;
  fractal_stream_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .din   ({frame_start_in, line_end_in, data_in}),
    .full  (full),
    .pop   (pop),
    .dout  (dout),
    .empty (empty)
  );
  // resync FSM: drop until a frame start fits, leave RUN on any overflow
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    ovf_evt = 1'b0;
    pop     = !empty && m_axis_tready;
    space   = !full || pop;
    if (data_enable_in) begin
      case (state_q)
        WAIT_SOF: begin
          push    = frame_start_in && space;
          drop    = !push;
          ovf_evt = frame_start_in && !space;
          state_d = push ? RUN : WAIT_SOF;
        end
        default: begin
          push    = space;
          drop    = !space;
          ovf_evt = !space;
          state_d = space ? RUN : WAIT_SOF;
        end
      endcase
    end
  end
  // sticky overflow and saturating drop counter; a drop in the clear cycle wins
  always_comb begin
    overflow_d   = ovf_evt || (overflow_q && !overflow_clear);
    drop_count_d = drop ? (overflow_clear ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} :
                           &drop_count_q ? drop_count_q : drop_count_q + 1'b1) :
                   overflow_clear ? '0 : drop_count_q;
  end
  // state and status registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= WAIT_SOF;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end
  // AXIS mapping; fields forced to zero when no beat is presented
  always_comb begin
    m_axis_tvalid = !empty;
    m_axis_tdata  = empty ? '0 : dout[DATA_WIDTH-1:0];
    m_axis_tuser  = !empty && dout[EW-1];
    m_axis_tlast  = !empty && dout[DATA_WIDTH];
    overflow      = overflow_q;
    drop_count    = drop_count_q;
    syncing       = state_q == WAIT_SOF;
  end
endmodule

// File: tb/tb_fractal_stream_to_axis.sv
// tb_fractal_stream_to_axis: directed self-checking bench for the pixel-to-AXIS bridge
module tb_fractal_stream_to_axis;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [23:0] data_in = '0;
  logic        frame_start_in = 1'b0, line_end_in = 1'b0, data_enable_in = 1'b0;
  logic        overflow_clear = 1'b0;
  logic        rdy64 = 1'b1, rdy4 = 1'b1;
  logic [23:0] td64, td4;
  logic        tu64, tl64, tv64, ov64, sy64, tu4, tl4, tv4, ov4, sy4;
  logic [15:0] dc64, dc4;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  fractal_stream_to_axis #(.DEPTH(64)) u64 (
    .clk(clk), .resetn(resetn), .data_in(data_in), .frame_start_in(frame_start_in),
    .line_end_in(line_end_in), .data_enable_in(data_enable_in),
    .m_axis_tdata(td64), .m_axis_tuser(tu64), .m_axis_tlast(tl64), .m_axis_tvalid(tv64),
    .m_axis_tready(rdy64), .overflow(ov64), .overflow_clear(overflow_clear),
    .drop_count(dc64), .syncing(sy64)
  );

  fractal_stream_to_axis #(.DEPTH(4)) u4 (
    .clk(clk), .resetn(resetn), .data_in(data_in), .frame_start_in(frame_start_in),
    .line_end_in(line_end_in), .data_enable_in(data_enable_in),
    .m_axis_tdata(td4), .m_axis_tuser(tu4), .m_axis_tlast(tl4), .m_axis_tvalid(tv4),
    .m_axis_tready(rdy4), .overflow(ov4), .overflow_clear(overflow_clear),
    .drop_count(dc4), .syncing(sy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [23:0] d, input logic sof, input logic eol);
    data_in = d;
    frame_start_in = sof;
    line_end_in = eol;
    data_enable_in = 1'b1;
  endtask

  task automatic idle();
    data_enable_in = 1'b0;
    frame_start_in = 1'b1;
    line_end_in = 1'b1;
    data_in = 24'hFFFFFF;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    // reset state
    do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_tvalid", 32'(tv64), 32'd0);
    chk("rst_tuser", 32'(tu64), 32'd0);
    chk("rst_tlast", 32'(tl64), 32'd0);
    chk("rst_tdata", 32'(td64), 32'd0);
    chk("rst_overflow", 32'(ov64), 32'd0);
    chk("rst_drop", 32'(dc64), 32'd0);
    chk("rst_syncing", 32'(sy64), 32'd1);
    tick();
    resetn = 1'b1;

    // three lines of four pixels, one-cycle latency
    rdy64 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      beat(24'(i), i == 1, i % 4 == 0);
      tick();
      chk("line_tvalid", 32'(tv64), 32'd1);
      chk("line_tdata", 32'(td64), 32'(i));
      chk("line_tuser", 32'(tu64), 32'(i == 1));
      chk("line_tlast", 32'(tl64), 32'(i % 4 == 0));
    end
    idle();
    tick();
    chk("line_drained", 32'(tv64), 32'd0);
    chk("line_drop", 32'(dc64), 32'd0);
    chk("line_syncing", 32'(sy64), 32'd0);

    // beats before frame start are discarded
    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat(24'h000100 + 24'(i), 1'b0, 1'b0);
      tick();
    end
    chk("presof_drop", 32'(dc64), 32'd5);
    chk("presof_tvalid", 32'(tv64), 32'd0);
    chk("presof_syncing", 32'(sy64), 32'd1);
    beat(24'hABCDEF, 1'b1, 1'b0);
    tick();
    chk("sof_tdata", 32'(td64), 32'h00ABCDEF);
    chk("sof_tuser", 32'(tu64), 32'd1);
    chk("sof_syncing", 32'(sy64), 32'd0);
    idle();
    tick();
    chk("sof_drained", 32'(tv64), 32'd0);

    // stall for ten cycles while eight beats arrive
    rdy64 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) beat(24'h000200 + 24'(i), 1'b0, 1'b0);
      else idle();
      tick();
      chk("stall_tvalid", 32'(tv64), 32'd1);
      chk("stall_tdata", 32'(td64), 32'h200);
    end
    idle();
    rdy64 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("stall_drain", 32'(td64), 32'h200 + 32'(i));
      tick();
    end
    chk("stall_empty", 32'(tv64), 32'd0);
    chk("stall_drop", 32'(dc64), 32'd5);
    chk("stall_overflow", 32'(ov64), 32'd0);

    // DEPTH=4 overflow and resync
    do_reset();
    rdy4 = 1'b1;
    beat(24'h000300, 1'b1, 1'b0);
    tick();
    chk("ov_first", 32'(td4), 32'h300);
    idle();
    tick();
    chk("ov_first_gone", 32'(tv4), 32'd0);
    rdy4 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      beat(24'h000300 + 24'(i), 1'b0, 1'b0);
      tick();
      chk("ov_overflow", 32'(ov4), 32'(i >= 5));
      chk("ov_drop", 32'(dc4), 32'(i >= 5 ? i - 4 : 0));
    end
    chk("ov_syncing", 32'(sy4), 32'd1);
    chk("ov_head", 32'(td4), 32'h301);
    idle();
    rdy4 = 1'b1;
    tick();
    rdy4 = 1'b0;
    chk("ov_pop", 32'(td4), 32'h302);
    beat(24'h000400, 1'b1, 1'b0);
    tick();
    chk("ov_resync", 32'(sy4), 32'd0);
    chk("ov_resync_drop", 32'(dc4), 32'd2);
    idle();
    rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ov_drain", 32'(td4), i == 3 ? 32'h400 : 32'h302 + 32'(i));
      chk("ov_drain_tuser", 32'(tu4), 32'(i == 3));
      tick();
    end
    chk("ov_drain_empty", 32'(tv4), 32'd0);

    // clear, then write into full FIFO while popping
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    chk("clr_overflow", 32'(ov4), 32'd0);
    chk("clr_drop", 32'(dc4), 32'd0);
    rdy4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      beat(24'h000500 + 24'(i), 1'b0, 1'b0);
      tick();
    end
    rdy4 = 1'b1;
    beat(24'h000505, 1'b0, 1'b0);
    tick();
    chk("fullpop_tdata", 32'(td4), 32'h502);
    chk("fullpop_overflow", 32'(ov4), 32'd0);
    chk("fullpop_drop", 32'(dc4), 32'd0);
    chk("fullpop_syncing", 32'(sy4), 32'd0);
    rdy4 = 1'b0;
    beat(24'h000506, 1'b0, 1'b0);
    tick();
    chk("fullpop_still_full", 32'(ov4), 32'd1);
    chk("fullpop_drop2", 32'(dc4), 32'd1);
    idle();

    // async reset mid-frame
    do_reset();
    rdy64 = 1'b0;
    rdy4 = 1'b1;
    beat(24'h000600, 1'b1, 1'b0);
    tick();
    beat(24'h000601, 1'b0, 1'b0);
    tick();
    beat(24'h000602, 1'b1, 1'b1);
    tick();
    idle();
    chk("mid_tvalid_pre", 32'(tv64), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_tvalid", 32'(tv64), 32'd0);
    chk("mid_tdata", 32'(td64), 32'd0);
    chk("mid_syncing", 32'(sy64), 32'd1);
    chk("mid_drop", 32'(dc64), 32'd0);
    tick();
    resetn = 1'b1;
    beat(24'h000700, 1'b0, 1'b0);
    tick();
    idle();
    chk("post_tvalid", 32'(tv64), 32'd0);
    chk("post_drop", 32'(dc64), 32'd1);
    chk("post_syncing", 32'(sy64), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
